// File: rtl/addsub_pkg.sv
// addsub_pkg -- shared definitions for the add/sub round-robin scheduler.
//   OP_ADD / OP_SUB : operation encoding carried on req_sub
//   rsp_state_e     : response register occupancy (EMPTY / FULL)
//   rr_pick()       : rotating-priority pick, returns a one-hot grant
// The response record (rsp_t) depends on N and NREQ, so it is declared
// inside addsub_rr_scheduler, where those parameters are in scope.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // rr_pick works on a fixed-width vector so that one function serves any NREQ.
  // Callers zero-extend their request vector and keep only the low NREQ bits.
  localparam int RR_MAX   = 64;
  localparam int RR_PTR_W = 6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  // Scan from ptr upward, wrapping at nreq. The first valid index wins.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0]   valid,
                                                input logic [RR_PTR_W-1:0] ptr,
                                                input int                  nreq);
    logic [RR_MAX-1:0]   grant;
    logic                found;
    int                  idx;
    logic [RR_PTR_W-1:0] bit_sel;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      bit_sel = idx[RR_PTR_W-1:0];
      if ((k < nreq) && !found && valid[bit_sel]) begin
        grant[bit_sel] = 1'b1;
        found          = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/addsub_rr_scheduler_arb.sv
// rr_arbiter -- purely combinational round-robin arbiter.
//   valid     [NREQ] : request lines
//   enable           : when low, no grant is given
//   ptr       [IDW]  : highest-priority index for this cycle
//   grant     [NREQ] : one-hot grant (all zero when nothing is granted)
//   grant_idx [IDW]  : binary index of the granted line (0 when no grant)
module rr_arbiter
  import addsub_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic            enable,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [RR_MAX-1:0]      valid_ext;
  logic [RR_MAX-1:0]      pick;
  logic [RR_MAX-NREQ-1:0] unused_pick_hi;

  assign valid_ext      = RR_MAX'(valid);
  assign pick           = rr_pick(valid_ext, RR_PTR_W'(ptr), NREQ);
  assign unused_pick_hi = pick[RR_MAX-1:NREQ];
  assign grant          = enable ? pick[NREQ-1:0] : '0;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// addsub_rr_scheduler -- shares one N-bit ripple add/sub among NREQ requesters.
// Round-robin issue of one operation per cycle into a single-entry response
// register. Optional build macro: ADDSUB_SAT_EN (clamp the result on signed
// overflow; carry/overflow flags are always reported unclamped).
//   clk, rst (async, active-high)
//   req_valid/req_ready [NREQ]  : request handshake, req_ready is a one-hot grant
//   req_a/req_b [NREQ*N]        : operands, requester i at [i*N +: N]
//   req_sub [NREQ]              : 1 = A-B, 0 = A+B
//   rsp_valid/rsp_ready         : response handshake
//   rsp_id/rsp_result/rsp_carry/rsp_overflow : registered response
//
// state    | meaning
// ST_EMPTY | response register holds nothing; any valid request may issue
// ST_FULL  | response held; a new issue needs rsp_ready in the same cycle
module addsub_rr_scheduler
  import addsub_pkg::*;
#(
  parameter  int N    = 32,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [N-1:0]    rsp_result,
  output logic            rsp_carry,
  output logic            rsp_overflow
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   result;
    logic           carry;
    logic           overflow;
  } rsp_t;

  rsp_state_e     state_q, state_d;
  rsp_t           rsp_q, rsp_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic            can_issue;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            any_grant;

  logic [N-1:0] op_a, op_b, b_eff, sum, result;
  logic         op_sub;
  logic [N-1:0] carry_vec;
  logic         ovf;

  // rst gates issue so req_ready is low for the whole reset window.
  assign can_issue = !rst && ((state_q == ST_EMPTY) || rsp_ready);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid     (req_valid),
    .enable    (can_issue),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    op_sub = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        op_a   = req_a[i*N +: N];
        op_b   = req_b[i*N +: N];
        op_sub = (req_sub[i] == OP_SUB);
      end
    end
  end

  // Single shared ripple chain; carry_vec[i] is the carry out of bit i.
  always_comb begin
    logic c;
    b_eff     = op_b ^ {N{op_sub}};
    c         = op_sub;
    sum       = '0;
    carry_vec = '0;
    for (int i = 0; i < N; i++) begin
      sum[i]       = op_a[i] ^ b_eff[i] ^ c;
      c            = (op_a[i] & b_eff[i]) | (op_a[i] & c) | (b_eff[i] & c);
      carry_vec[i] = c;
    end
  end

  assign ovf = carry_vec[N-1] ^ carry_vec[N-2];

`ifdef ADDSUB_SAT_EN
  // Overflow is only possible when both effective operands share A's sign,
  // so A's MSB selects the clamp direction.
  assign result = !ovf        ? sum :
                  op_a[N-1]   ? {1'b1, {(N-1){1'b0}}} :
                                {1'b0, {(N-1){1'b1}}};
`else
  assign result = sum;
`endif

  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      state_d        = ST_FULL;
      rsp_d.id       = grant_idx;
      rsp_d.result   = result;
      rsp_d.carry    = carry_vec[N-1];
      rsp_d.overflow = ovf;
      rr_ptr_d       = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rsp_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rsp_q    <= rsp_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid    = (state_q == ST_FULL);
  assign rsp_id       = rsp_q.id;
  assign rsp_result   = rsp_q.result;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_overflow = rsp_q.overflow;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler, N=8, NREQ=4.
module tb_addsub_rr_scheduler;

  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [N-1:0]    rsp_result;
  logic            rsp_carry;
  logic            rsp_overflow;

  int n_cmp = 0;
  int n_bad = 0;

  addsub_rr_scheduler #(.N(N), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic sub);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_sub[i]      = sub;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] res,
                         input logic cy, input logic ov);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".id"},    32'(rsp_id), 32'(id));
    chk({tag, ".res"},   32'(rsp_result), 32'(res));
    chk({tag, ".carry"}, 32'(rsp_carry), 32'(cy));
    chk({tag, ".ovf"},   32'(rsp_overflow), 32'(ov));
  endtask

  logic [3:0] exp_grant [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] exp_sat_80;
  logic [7:0] exp_sat_7f;

  initial begin
`ifdef ADDSUB_SAT_EN
    exp_sat_80 = 8'h7F;
    exp_sat_7f = 8'h80;
`else
    exp_sat_80 = 8'h80;
    exp_sat_7f = 8'h7F;
`endif
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_id",    32'(rsp_id), 32'd0);
    chk("rst.result",    32'(rsp_result), 32'd0);
    chk("rst.carry",     32'(rsp_carry), 32'd0);
    chk("rst.ovf",       32'(rsp_overflow), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);

    // 1: req0 5+3
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 8'h05, 8'h03, 1'b0);
    #1 chk("t1.grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk_rsp("t1", 2'd0, 8'h08, 1'b0, 1'b0);

    // 2a: req1 3-5, draining and refilling in one cycle
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    set_req(1, 8'h03, 8'h05, 1'b1);
    #1 chk("t2a.grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk_rsp("t2a", 2'd1, 8'hFE, 1'b0, 1'b0);

    // 2b: req2 0x7F+0x01 overflows
    @(negedge clk);
    req_valid = 4'b0100;
    set_req(2, 8'h7F, 8'h01, 1'b0);
    #1 chk("t2b.grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk_rsp("t2b", 2'd2, exp_sat_80, 1'b0, 1'b1);

    // 3: all valid, rsp_ready=1; pointer sits at 3 after the previous grants
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i * 16 + 1), 8'(i), 1'b0);
    @(negedge clk);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("t3.grant%0d", k), 32'(req_ready), 32'(exp_grant[k]));
      @(posedge clk); #1;
      chk($sformatf("t3.valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("t3.id%0d", k), 32'(rsp_id), 32'($clog2(exp_grant[k])));
      @(negedge clk);
    end
    // last grant was req0: A=0x01 B=0x00 -> 0x01 held

    // 4: backpressure with req3 waiting, then 5: req3 0x80-0x01
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    set_req(3, 8'h80, 8'h01, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4.ready%0d", k), 32'(req_ready), 32'd0);
      chk($sformatf("t4.id%0d", k), 32'(rsp_id), 32'd0);
      chk($sformatf("t4.res%0d", k), 32'(rsp_result), 32'h01);
      chk($sformatf("t4.valid%0d", k), 32'(rsp_valid), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("t4.release_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk_rsp("t5", 2'd3, exp_sat_7f, 1'b1, 1'b1);

    // 6: move pointer to 2, then async reset while FULL
    @(negedge clk);
    req_valid = 4'b0010;
    set_req(1, 8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    chk_rsp("t6.pre", 2'd1, 8'h30, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6.async_valid", 32'(rsp_valid), 32'd0);
    chk("t6.async_res",   32'(rsp_result), 32'd0);
    req_valid = 4'b0110;
    set_req(2, 8'h02, 8'h02, 1'b0);
    #1 chk("t6.rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("t6.first_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    chk_rsp("t6.post", 2'd1, 8'h30, 1'b0, 1'b0);

    // FULL & rsp_ready, req2 takes the slot; then no request drains to EMPTY
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("t7.grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    chk_rsp("t7", 2'd2, 8'h04, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("t7.drain", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
